// File: rtl/avalon_mm_cmd_master_if.sv
// Bundle of the local command/response channels and the Avalon-MM master bus.
// The master modport is the view of the command master itself; the slave
// modport is the view of whatever drives commands and models the Avalon slave.
interface avalon_mm_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Local command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_address;
  logic [DATA_W-1:0]     cmd_writedata;
  logic [DATA_W/8-1:0]   cmd_byteenable;
  // Local response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic                  rsp_error;
  logic [DATA_W-1:0]     rsp_readdata;
  // Avalon-MM master bus
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_error, rsp_readdata,
    input  rsp_ready,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_error, rsp_readdata,
    output rsp_ready,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/avalon_mm_cmd_master.sv
// Single-outstanding Avalon-MM master: one local command beat becomes one
// Avalon read or write, answered by one response beat. Waitrequest stalls and
// variable read latency are tolerated; a transfer that stays busy for
// TIMEOUT_CYCLES cycles is abandoned and answered with rsp_error=1.
module avalon_mm_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_mm_cmd_master_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  // Counter only has to reach TIMEOUT_CYCLES-1; one extra value of headroom.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RSP     = 3'd4
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [DATA_W-1:0]   r_wdata, w_wdata_next;
  logic [BE_W-1:0]     r_be, w_be_next;
  logic                r_is_write, w_is_write_next;
  logic                r_rsp_write, w_rsp_write_next;
  logic                r_rsp_error, w_rsp_error_next;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                w_timeout;

  // Strobes and handshakes decode straight from the state register.
  assign bus.cmd_ready      = (r_state == S_IDLE);
  assign bus.avm_write      = (r_state == S_WR);
  assign bus.avm_read       = (r_state == S_RD_REQ);
  assign bus.rsp_valid      = (r_state == S_RSP);
  assign bus.avm_address    = r_addr;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_byteenable = r_be;
  assign bus.rsp_write      = r_rsp_write;
  assign bus.rsp_error      = r_rsp_error;
  assign bus.rsp_readdata   = r_rsp_data;

  // Next-state and next-datapath logic; completion is tested before timeout
  // so a transfer finishing in its last allowed cycle is not reported as error.
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_be_next        = r_be;
    w_is_write_next  = r_is_write;
    w_rsp_write_next = r_rsp_write;
    w_rsp_error_next = r_rsp_error;
    w_rsp_data_next  = r_rsp_data;
    w_cnt_next       = r_cnt;
    w_timeout        = (r_cnt == CNT_LAST);

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_addr_next     = bus.cmd_address;
          w_wdata_next    = bus.cmd_writedata;
          w_be_next       = bus.cmd_byteenable;
          w_is_write_next = bus.cmd_write;
          w_cnt_next      = '0;
          w_state_next    = bus.cmd_write ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (!bus.avm_waitrequest) begin
          w_rsp_write_next = 1'b1;
          w_rsp_error_next = 1'b0;
          w_rsp_data_next  = '0;
          w_state_next     = S_RSP;
        end else if (w_timeout) begin
          w_rsp_write_next = 1'b1;
          w_rsp_error_next = 1'b1;
          w_rsp_data_next  = '0;
          w_state_next     = S_RSP;
        end
      end
      S_RD_REQ: begin
        w_cnt_next = r_cnt + 1'b1;
        if (!bus.avm_waitrequest && bus.avm_readdatavalid) begin
          w_rsp_write_next = 1'b0;
          w_rsp_error_next = 1'b0;
          w_rsp_data_next  = bus.avm_readdata;
          w_state_next     = S_RSP;
        end else if (w_timeout) begin
          w_rsp_write_next = 1'b0;
          w_rsp_error_next = 1'b1;
          w_rsp_data_next  = '0;
          w_state_next     = S_RSP;
        end else if (!bus.avm_waitrequest) begin
          w_state_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (bus.avm_readdatavalid) begin
          w_rsp_write_next = 1'b0;
          w_rsp_error_next = 1'b0;
          w_rsp_data_next  = bus.avm_readdata;
          w_state_next     = S_RSP;
        end else if (w_timeout) begin
          w_rsp_write_next = 1'b0;
          w_rsp_error_next = 1'b1;
          w_rsp_data_next  = '0;
          w_state_next     = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transfer without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: captured command, response fields and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_is_write  <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
      r_cnt       <= '0;
    end else begin
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_be        <= w_be_next;
      r_is_write  <= w_is_write_next;
      r_rsp_write <= w_rsp_write_next;
      r_rsp_error <= w_rsp_error_next;
      r_rsp_data  <= w_rsp_data_next;
      r_cnt       <= w_cnt_next;
    end
  end
endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Bench for avalon_mm_cmd_master. Each transaction is described by a few
// numbers (waitrequest cycles, read latency, response backpressure); the
// expected cycle-by-cycle outputs follow from those numbers with plain
// arithmetic, and one compare process checks the DUT on every cycle.
module tb_avalon_mm_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_mm_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  avalon_mm_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Expectations for the current cycle, written by the driver
  bit          chk_en = 1'b0;
  bit          exp_zero, exp_accept, exp_cmd_ready, exp_write, exp_read;
  bit          exp_rsp_valid, exp_rsp_write, exp_rsp_error;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  int n_pass = 0;
  int n_checks = 0;

  // Per-transaction observations used by the literal checks
  int          mon_age, mon_strobes, mon_lat;
  bit          mon_seen, mon_err;
  logic [31:0] mon_rdata;

  // Slave memory model (16 words)
  logic [31:0] mem [16];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare process: checks outputs mid-cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check1("cmd_ready", bus.cmd_ready, exp_cmd_ready);
      check1("avm_write", bus.avm_write, exp_write);
      check1("avm_read", bus.avm_read, exp_read);
      check1("rsp_valid", bus.rsp_valid, exp_rsp_valid);
      if (exp_write || exp_read) begin
        check32("avm_address", bus.avm_address, exp_addr);
        check32("avm_byteenable", 32'(bus.avm_byteenable), 32'(exp_be));
        if (exp_write) check32("avm_writedata", bus.avm_writedata, exp_wdata);
      end
      if (exp_rsp_valid) begin
        check1("rsp_write", bus.rsp_write, exp_rsp_write);
        check1("rsp_error", bus.rsp_error, exp_rsp_error);
        check32("rsp_readdata", bus.rsp_readdata, exp_rdata);
      end
      if (exp_zero) begin
        check32("zero_address", bus.avm_address, 32'h0);
        check32("zero_writedata", bus.avm_writedata, 32'h0);
        check32("zero_byteenable", 32'(bus.avm_byteenable), 32'h0);
        check1("zero_rsp_write", bus.rsp_write, 1'b0);
        check1("zero_rsp_error", bus.rsp_error, 1'b0);
        check32("zero_rsp_readdata", bus.rsp_readdata, 32'h0);
      end
    end
    if (exp_accept) begin
      mon_age = 0; mon_strobes = 0; mon_seen = 1'b0;
    end else begin
      mon_age++;
    end
    if (bus.avm_write || bus.avm_read) mon_strobes++;
    if (bus.rsp_valid && !mon_seen) begin
      mon_seen  = 1'b1;
      mon_lat   = mon_age;
      mon_rdata = bus.rsp_readdata;
      mon_err   = bus.rsp_error;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_cmd_ready = 1'b1; exp_write = 1'b0; exp_read = 1'b0;
    exp_rsp_valid = 1'b0; exp_accept = 1'b0; exp_zero = 1'b0;
  endtask

  // Random values on inputs the DUT should not care about this cycle
  task automatic noise_inputs();
    bus.avm_waitrequest   = 1'($urandom);
    bus.avm_readdatavalid = ($urandom_range(0, 3) == 0);
    bus.avm_readdata      = $urandom;
    bus.rsp_ready         = 1'($urandom);
  endtask

  task automatic junk_cmd();
    bus.cmd_valid      = 1'($urandom);
    bus.cmd_write      = 1'($urandom);
    bus.cmd_address    = $urandom;
    bus.cmd_writedata  = $urandom;
    bus.cmd_byteenable = 4'($urandom);
  endtask

  // One transaction. Cycle index i counts from the first cycle after accept.
  // w: cycles of waitrequest, l: cycles from request accept to read data,
  // bp: cycles rsp_ready is held low once the response is offered.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input int w, input int l, input int bp,
                         input logic [31:0] rdata, input int gap);
    int s, e, r, last, dat_idx;
    bit err;
    for (int g = 0; g < gap; g++) begin
      noise_inputs(); bus.cmd_valid = 1'b0; set_idle_exp(); step();
    end
    noise_inputs();
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_address = addr;
    bus.cmd_writedata = data; bus.cmd_byteenable = be;
    set_idle_exp(); exp_accept = 1'b1;
    step();
    dat_idx = wr ? w : w + l;              // cycle on which the transfer completes
    s    = (w + 1 < T) ? w + 1 : T;        // cycles the strobe is high
    e    = (dat_idx < T - 1) ? dat_idx : T - 1;
    err  = (dat_idx > T - 1);
    r    = e + 1;                          // first cycle of rsp_valid
    last = r + bp;                         // handshake cycle
    exp_addr = addr; exp_wdata = data; exp_be = be;
    exp_rsp_write = wr; exp_rsp_error = err;
    exp_rdata = (wr || err) ? 32'h0 : rdata;
    for (int i = 0; i <= last || (!wr && i <= dat_idx); i++) begin
      noise_inputs();
      if (i < s) bus.avm_waitrequest = (i < w);
      if (!wr) bus.avm_readdatavalid = (i == dat_idx);
      if (!wr && i == dat_idx) bus.avm_readdata = rdata;
      if (i >= r && i <= last) bus.rsp_ready = (i == last);
      if (i <= last) junk_cmd(); else bus.cmd_valid = 1'b0;
      exp_accept = 1'b0; exp_zero = 1'b0;
      exp_cmd_ready = (i > last);
      exp_write = wr && (i < s);
      exp_read  = !wr && (i < s);
      exp_rsp_valid = (i >= r) && (i <= last);
      step();
    end
    bus.cmd_valid = 1'b0;
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  bit          r_wr;
  logic [31:0] r_a, r_d;
  logic [3:0]  r_be;
  int          r_w, r_l, r_bp, r_gap;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0;
    bus.cmd_writedata = '0; bus.cmd_byteenable = '0; bus.rsp_ready = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0; bus.avm_readdatavalid = 1'b0;
    set_idle_exp();
    reset = 1'b1;
    step();
    // After a reset edge: all outputs 0 except cmd_ready
    set_idle_exp(); exp_zero = 1'b1; chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_zero = 1'b0;

    // Zero-wait write
    run_txn(1'b1, 32'h0, 32'h12345678, 4'hF, 0, 0, 0, 32'h0, 0);
    check32("wr0_strobes", 32'(mon_strobes), 32'd1);
    check32("wr0_latency", 32'(mon_lat), 32'd2);
    // Write stalled 3 cycles
    run_txn(1'b1, 32'h10, 32'hCAFEF00D, 4'h5, 3, 0, 0, 32'h0, 1);
    check32("wrstall_strobes", 32'(mon_strobes), 32'd4);
    check32("wrstall_latency", 32'(mon_lat), 32'd5);
    // Read, latency 2
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 2, 0, 32'hDEADBEEF, 0);
    check32("rd2_strobes", 32'(mon_strobes), 32'd1);
    check32("rd2_data", mon_rdata, 32'hDEADBEEF);
    check32("rd2_latency", 32'(mon_lat), 32'd4);
    // Read, data in the acceptance cycle
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 0, 32'hDEADBEEF, 0);
    check32("rd0_data", mon_rdata, 32'hDEADBEEF);
    check32("rd0_latency", 32'(mon_lat), 32'd2);
    // Write timeout: waitrequest stuck high
    run_txn(1'b1, 32'h8, 32'h11112222, 4'hF, 40, 0, 0, 32'h0, 0);
    check32("wrto_strobes", 32'(mon_strobes), 32'd8);
    check1("wrto_error", mon_err, 1'b1);
    check32("wrto_data", mon_rdata, 32'h0);
    check32("wrto_latency", 32'(mon_lat), 32'd9);
    // Normal write right after the timeout
    run_txn(1'b1, 32'hC, 32'h33334444, 4'hF, 0, 0, 0, 32'h0, 0);
    check1("after_to_error", mon_err, 1'b0);
    check32("after_to_latency", 32'(mon_lat), 32'd2);
    // Response backpressure 5 cycles (junk commands offered meanwhile)
    run_txn(1'b1, 32'h14, 32'h55556666, 4'hF, 0, 0, 5, 32'h0, 0);
    check32("bp_latency", 32'(mon_lat), 32'd2);
    // Read timeout in RD_WAIT; late data arrives after the response
    run_txn(1'b0, 32'h18, 32'h0, 4'hF, 1, 12, 0, 32'h77778888, 0);
    check32("rdto_strobes", 32'(mon_strobes), 32'd2);
    check1("rdto_error", mon_err, 1'b1);
    check32("rdto_latency", 32'(mon_lat), 32'd9);

    // Reset while waiting for read data
    noise_inputs();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 32'h8;
    bus.cmd_byteenable = 4'hF;
    set_idle_exp(); exp_accept = 1'b1;
    step();
    exp_addr = 32'h8; exp_be = 4'hF;
    noise_inputs(); bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
    bus.cmd_valid = 1'b0;
    set_idle_exp(); exp_cmd_ready = 1'b0; exp_read = 1'b1;
    step();
    noise_inputs(); bus.avm_readdatavalid = 1'b0;
    set_idle_exp(); exp_cmd_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    noise_inputs(); bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hBAADF00D;
    set_idle_exp(); exp_zero = 1'b1;
    step();
    noise_inputs();
    set_idle_exp(); exp_zero = 1'b1;
    step();
    exp_zero = 1'b0;
    run_txn(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 32'h0, 0);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 1, 1, 1, mem[0], 0);
    check32("pio_readback", mon_rdata, 32'hA5A5A5A5);
    check1("pio_readback_err", mon_err, 1'b0);

    // Randomized transactions against the slave memory model
    for (int k = 0; k < 80; k++) begin
      r_wr  = 1'($urandom);
      r_a   = {26'h0, 4'($urandom), 2'b00};
      r_d   = $urandom;
      r_be  = 4'($urandom);
      r_w   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3));
      r_l   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 10)) : int'($urandom_range(0, 2));
      r_bp  = int'($urandom_range(0, 3));
      r_gap = int'($urandom_range(0, 2));
      run_txn(r_wr, r_a, r_d, r_be, r_w, r_l, r_bp, mem[r_a[5:2]], r_gap);
    end

    chk_en = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/avalon_mm_cmd_master.md
Name: avalon_mm_cmd_master

Overview:
- Single-outstanding Avalon-MM master that turns local command beats into Avalon-MM read/write transfers.
- Typical targets are the team's PIO and CSR slaves.
- Sits between control logic (camera/VGA sequencers, test harnesses) and the Qsys interconnect, so hardware can program registers without the NIOS.
- Handles waitrequest stalls and variable-latency readdatavalid, and aborts hung transfers with a timeout error.

Parameters:
- ADDR_W, 32, Avalon address width (byte address).
- DATA_W, 32, data width; multiple of 8.
- TIMEOUT_CYCLES, 256, max cycles a transfer may stay in WR/RD_REQ/RD_WAIT before abort; >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target address.
- cmd_writedata  in  DATA_W  write data.
- cmd_byteenable  in  DATA_W/8  byte lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  response belongs to a write.
- rsp_error  out  1  transfer timed out.
- rsp_readdata  out  DATA_W  read data; 0 for writes and errors.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_byteenable  out  DATA_W/8  Avalon byteenable.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  slave read data.
- avm_readdatavalid  in  1  read data qualifier.

Behaviour:
- Reset: clk and reset only, as decided: single clock domain, synchronous active-high reset. reset=1 at a clk edge forces state IDLE and clears all outputs to 0 except cmd_ready, which is 1 from the first cycle after reset. Applies mid-transfer too: an aborted in-flight transfer produces no response.
- States: IDLE, WR, RD_REQ, RD_WAIT, RSP.
- IDLE:
  - cmd_ready=1; all other outputs hold 0 / previous rsp fields.
  - On accept: register address, writedata and byteenable onto the avm_* outputs; clear the timeout counter.
  - Go to WR (cmd_write=1) or RD_REQ (cmd_write=0). avm_write/avm_read assert on the cycle after accept.
- cmd_ready=0 in every state other than IDLE. No pipelining: exactly one transfer outstanding.
- WR:
  - avm_write=1; address, data and byteenable stable until a cycle where avm_waitrequest=0.
  - On that cycle the transfer completes. Next cycle: avm_write=0; RSP with rsp_write=1, rsp_error=0, rsp_readdata=0.
- RD_REQ:
  - avm_read=1 until a cycle with avm_waitrequest=0.
  - If avm_readdatavalid=1 in that same cycle, capture avm_readdata and go to RSP.
  - Otherwise go to RD_WAIT with avm_read=0.
- RD_WAIT:
  - Wait for avm_readdatavalid=1, capture avm_readdata, then RSP with rsp_write=0, rsp_error=0.
- RSP:
  - rsp_valid=1; rsp fields held stable until rsp_ready=1.
  - Then return to IDLE, with cmd_ready=1 on the next cycle. rsp_valid deasserts the cycle after the handshake.
- Minimum latencies:
  - Write: accept to rsp_valid = 2 cycles (accept edge, avm_write cycle, rsp_valid).
  - Read with readdatavalid in the acceptance cycle: same as write.
- Timeout:
  - Counter increments each cycle in WR/RD_REQ/RD_WAIT.
  - In the cycle where counter == TIMEOUT_CYCLES-1 with no completion: deassert avm_read/avm_write next cycle, go to RSP with rsp_error=1, rsp_readdata=0, rsp_write = command type.
- Completion and timeout in the same cycle: completion wins, rsp_error=0.
- avm_readdatavalid while in IDLE, WR or RSP (e.g. late data after a timeout): ignored. Captured only in RD_REQ/RD_WAIT.
- cmd_* inputs are ignored when cmd_ready=0.

Test Plan:
- Write with zero wait: cmd addr=0x0, data=0x12345678, be=0xF, waitrequest=0 -> avm_write high exactly 1 cycle with those values; rsp_valid 2 cycles after accept, rsp_write=1, rsp_error=0.
- Wait-stalled write: waitrequest=1 for 3 cycles -> avm_write high 4 cycles with address/data stable; single response.
- Read with readdatavalid latency 2 returning 0xDEADBEEF -> avm_read 1 cycle; rsp_readdata=0xDEADBEEF, rsp_write=0. Repeat with latency 0 -> same result, no RD_WAIT.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck 1 -> avm_write high exactly 8 cycles; rsp_error=1, rsp_readdata=0. A later stray readdatavalid is ignored; the next command completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0 throughout; second cmd_valid accepted only after the handshake.
- Reset mid-read while in RD_WAIT -> next cycle all outputs 0 except cmd_ready=1; no rsp_valid; following write to a PIO slave (addr 0, 0xA5A5A5A5) then read-back returns 0xA5A5A5A5.
